// File: rtl/alu_seq_if.sv
// Request/response bundle for the sequential ALU.
// Master issues start/op/operands; slave returns status and result.
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             carry;
   logic             overflow;

   modport master (
      output start, op, operand1, operand2,
      input  busy, done, result, result_hi,
      input  zero, carry, overflow
   );

   modport slave (
      input  start, op, operand1, operand2,
      output busy, done, result, result_hi,
      output zero, carry, overflow
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: one-cycle logic/arith ops and a
// shift-add unsigned multiply taking WIDTH steps.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_t;

   state_t           state, nstate;
   logic [CW-1:0]    cnt, ncnt;
   logic [WIDTH-1:0] mcand, nmcand;
   logic [WIDTH-1:0] ph, nph;
   logic [WIDTH-1:0] pl, npl;
   logic [WIDTH-1:0] res_q, nres;
   logic [WIDTH-1:0] hi_q, nhi;
   logic             z_q, nz;
   logic             c_q, nc;
   logic             v_q, nv;
   logic [WIDTH:0]   add_s, sub_s, step;
   logic [WIDTH-1:0] a, b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         mcand <= '0;
         ph    <= '0;
         pl    <= '0;
         res_q <= '0;
         hi_q  <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
         mcand <= nmcand;
         ph    <= nph;
         pl    <= npl;
         res_q <= nres;
         hi_q  <= nhi;
         z_q   <= nz;
         c_q   <= nc;
         v_q   <= nv;
      end
   end

   always_comb begin
      a      = bus.operand1;
      b      = bus.operand2;
      add_s  = {1'b0, a} + {1'b0, b};
      sub_s  = {1'b0, a} - {1'b0, b};
      // pl's low bit is the next multiplier bit; ph:pl shifts right each step
      step   = {1'b0, ph} + (pl[0] ? {1'b0, mcand} : '0);
      nstate = state;
      ncnt   = cnt;
      nmcand = mcand;
      nph    = ph;
      npl    = pl;
      nres   = res_q;
      nhi    = hi_q;
      nz     = z_q;
      nc     = c_q;
      nv     = v_q;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.op == 3'b100) begin
                  nstate = S_MUL;
                  ncnt   = '0;
                  nmcand = a;
                  nph    = '0;
                  npl    = b;
               end else begin
                  nstate = S_DONE;
                  nhi    = '0;
                  nc     = 1'b0;
                  nv     = 1'b0;
                  unique case (bus.op)
                     3'b000: nres = a;
                     3'b001: begin
                        nres = add_s[WIDTH-1:0];
                        nc   = add_s[WIDTH];
                        nv   = (a[WIDTH-1] == b[WIDTH-1]) &&
                               (add_s[WIDTH-1] != a[WIDTH-1]);
                     end
                     3'b010: begin
                        nres = sub_s[WIDTH-1:0];
                        nc   = sub_s[WIDTH];
                        nv   = (a[WIDTH-1] != b[WIDTH-1]) &&
                               (sub_s[WIDTH-1] != a[WIDTH-1]);
                     end
                     3'b011: nres = b;
                     3'b101: nres = a & b;
                     3'b110: nres = a | b;
                     3'b111: nres = a ^ b;
                     default: nres = '0;
                  endcase
                  nz = (nres == '0);
               end
            end
         end
         S_MUL: begin
            nph  = step[WIDTH:1];
            npl  = {step[0], pl[WIDTH-1:1]};
            ncnt = cnt + CW'(1);
            if (cnt == LAST) begin
               nstate = S_DONE;
               nres   = npl;
               nhi    = nph;
               nz     = (npl == '0) && (nph == '0);
               nc     = (nph != '0);
               nv     = 1'b0;
            end
         end
         S_DONE: nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (state != S_IDLE);
      bus.done      = (state == S_DONE);
      bus.result    = res_q;
      bus.result_hi = hi_q;
      bus.zero      = z_q;
      bus.carry     = c_q;
      bus.overflow  = v_q;
   end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8.
// Directed vectors; a monitor pops expectations on done.
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [18:0] exp_q[$];
   string       name_q[$];
   logic [7:0]  last_res = 8'h00;
   logic [7:0]  last_hi = 8'h00;

   alu_seq_if #(.WIDTH(8)) bus ();

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [18:0] act, ex;
      string nm;
      if (!rst && bus.done) begin
         checks++;
         act = {bus.result, bus.result_hi,
                bus.zero, bus.carry, bus.overflow};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done act=%h", act);
         end else begin
            ex = exp_q.pop_front();
            nm = name_q.pop_front();
            if (act !== ex) begin
               errors++;
               $display("FAIL %s res/hi/zcv act=%h exp=%h",
                        nm, act, ex);
            end
         end
      end
   end

   task automatic run(input string nm, input logic [2:0] o,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [7:0] eh,
                      input logic ez, input logic ec,
                      input logic ev, input int lat);
      int cyc, busyc;
      bit seen, held;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = o;
      bus.operand1 = a;
      bus.operand2 = b;
      exp_q.push_back({er, eh, ez, ec, ev});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op = ~o;
      bus.operand1 = ~a;
      bus.operand2 = b ^ 8'h5A;
      cyc = 0;
      busyc = 0;
      seen = 0;
      held = 1;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.busy) busyc++;
         if (bus.done) seen = 1;
         else if (bus.result !== last_res ||
                  bus.result_hi !== last_hi) held = 0;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout act=nodone exp=done", nm);
      end else if (cyc != lat) begin
         errors++;
         $display("FAIL %s latency act=%0d exp=%0d", nm, cyc, lat);
      end
      checks++;
      if (busyc != lat) begin
         errors++;
         $display("FAIL %s busy_cycles act=%0d exp=%0d",
                  nm, busyc, lat);
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL %s hold act=changed exp=%h/%h",
                  nm, last_hi, last_res);
      end
      last_res = er;
      last_hi = eh;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.result !== er || bus.result_hi !== eh) begin
         errors++;
         $display("FAIL %s post act=b%b d%b %h/%h exp=b0 d0 %h/%h",
                  nm, bus.busy, bus.done, bus.result_hi,
                  bus.result, eh, er);
      end
   endtask

   task automatic check_zero(input string nm);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.result !== 8'h00 || bus.result_hi !== 8'h00 ||
          bus.zero !== 1'b0 || bus.carry !== 1'b0 ||
          bus.overflow !== 1'b0) begin
         errors++;
         $display("FAIL %s act=b%b d%b %h/%h z%b c%b v%b exp=all0",
                  nm, bus.busy, bus.done, bus.result_hi,
                  bus.result, bus.zero, bus.carry, bus.overflow);
      end
   endtask

   initial begin
      int cyc;
      bit seen;
      bus.start = 1'b0;
      bus.op = 3'b000;
      bus.operand1 = 8'h00;
      bus.operand2 = 8'h00;
      #12;
      check_zero("reset_state");
      @(negedge clk);
      rst = 1'b0;

      run("pass1", 3'b000, 8'h5A, 8'h11, 8'h5A, 8'h00, 0, 0, 0, 1);
      run("add_carry", 3'b001, 8'hF0, 8'h20, 8'h10, 8'h00, 0, 1, 0, 1);
      run("add_ovf", 3'b001, 8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1, 1);
      run("sub_ovf", 3'b010, 8'h80, 8'h01, 8'h7F, 8'h00, 0, 0, 1, 1);
      run("sub_zero", 3'b010, 8'h33, 8'h33, 8'h00, 8'h00, 1, 0, 0, 1);
      run("sub_borrow", 3'b010, 8'h00, 8'h01, 8'hFF, 8'h00, 0, 1, 0, 1);
      run("pass2", 3'b011, 8'h12, 8'hC3, 8'hC3, 8'h00, 0, 0, 0, 1);
      run("mul_ff", 3'b100, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 1, 0, 9);
      run("mul_zero", 3'b100, 8'h00, 8'h37, 8'h00, 8'h00, 1, 0, 0, 9);
      run("mul_small", 3'b100, 8'h0C, 8'h0A, 8'h78, 8'h00, 0, 0, 0, 9);
      run("and_chg", 3'b101, 8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 1);
      run("or", 3'b110, 8'h0F, 8'h30, 8'h3F, 8'h00, 0, 0, 0, 1);
      run("xor_zero", 3'b111, 8'h5A, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1);

      // ADD request arriving at E3 of a multiply must be dropped
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 3'b100;
      bus.operand1 = 8'h03;
      bus.operand2 = 8'h05;
      exp_q.push_back({8'h0F, 8'h00, 1'b0, 1'b0, 1'b0});
      name_q.push_back("mul_ignore_start");
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op = 3'b001;
      bus.operand1 = 8'h01;
      bus.operand2 = 8'h01;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 3;
      seen = 0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.done) seen = 1;
      end
      checks++;
      if (cyc != 9 || !seen) begin
         errors++;
         $display("FAIL mul_ignore_latency act=%0d exp=9", cyc);
      end
      repeat (4) @(negedge clk);
      last_res = 8'h0F;
      last_hi = 8'h00;

      // reset mid-multiply: outputs clear at once, no done
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 3'b100;
      bus.operand1 = 8'h03;
      bus.operand2 = 8'h05;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      last_res = 8'h00;
      last_hi = 8'h00;
      repeat (12) @(negedge clk);
      check_zero("no_done_after_abort");

      run("xor_after_rst", 3'b111, 8'hAA, 8'hFF, 8'h55, 8'h00,
          0, 0, 0, 1);
      run("mul_3x5", 3'b100, 8'h03, 8'h05, 8'h0F, 8'h00, 0, 0, 0, 9);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain act=%0d exp=0",
                  exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
